addr_byte_serializer: RTL and testbench
=======================================

Name: addr_byte_serializer

Overview:
- Reverse of the effective-address unit's byte-assembly path: holds a 16-bit address and emits it as two bytes on the 8-bit data bus.
- Default order is low byte then high byte. Each byte moves under a valid/ready handshake.
- Used for PC/address pushes to the stack and for address writes to byte-wide peripherals.

Parameters:
- MSB_FIRST, 0, 1 = emit high byte first; 0 = low byte first.
- RESET_VALUE, 16'h0000, reset contents of the address holding register.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- a  input  16  address to capture.
- ai  input  1  load: capture a into the holding register.
- go  input  1  start a two-byte emission.
- clr  input  1  synchronous abort; returns the block to IDLE.
- dr  input  1  downstream ready for the byte on dq.
- dq  output  8  byte out.
- dv  output  1  dq valid.
- aq  output  16  current holding-register contents.
- busy  output  1  emission in progress (state != IDLE).
- done  output  1  one-cycle pulse after the second byte is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, aq=RESET_VALUE.
  - dq=8'h00, dv=0, busy=0, done=0.
- States: IDLE, FIRST, SECOND. All outputs are registered.
- IDLE:
  - ai=1 loads aq<=a on the clock edge.
  - go=1 moves to FIRST. dq<=first byte and dv<=1 take effect on the same edge.
  - ai and go in the same cycle: a is loaded and the emitted bytes come from a, not the old aq (load-through).
- Byte order:
  - First byte = aq[7:0] when MSB_FIRST=0, else aq[15:8]. Second byte is the other half.
- Handshake:
  - A byte transfers on any rising edge where dv=1 and dr=1.
  - While dv=1 and dr=0, dq and dv hold stable.
  - dr may be high before dv rises; that is legal and costs no extra cycle.
- FIRST:
  - On transfer, go to SECOND, dq<=second byte, dv stays 1.
  - No bubble: with dr held high the two bytes occupy consecutive cycles.
- SECOND:
  - On transfer, go to IDLE with dv<=0 and done<=1 for exactly one cycle.
- Latency:
  - go sampled at edge N gives first byte valid after edge N.
  - With dr=1 throughout, the bytes transfer at edges N+1 and N+2. done is high in the cycle after edge N+2.
- Back-to-back: go can be accepted in the cycle where done=1, since the block is already in IDLE. Minimum 3 cycles per address.
- ai and go while busy=1 are ignored. aq stays frozen for the whole emission.
- clr=1:
  - Any state goes to IDLE with dv<=0, done<=0. aq is kept.
  - clr has priority over go, ai and a handshake in the same cycle; that byte counts as not transferred.
- Reset mid-emission: immediate return to the reset values, and no done pulse.
- done is never asserted except following a completed SECOND transfer.

Test Plan:
- Reset values: rst=0 with dr=1 → dq=8'h00, dv=0, busy=0, done=0, aq=16'h0000. Release rst; 3 idle cycles → dv stays 0.
- Basic emission, MSB_FIRST=0:
  - Stimulus: a=16'h14F1, ai=1 for one cycle; then go=1 for one cycle; dr=1 throughout.
  - Response: dq=8'hF1 with dv=1, then dq=8'h14 on the next cycle; done high one cycle after that.
- Backpressure:
  - Stimulus: a=16'hBEEF, go=1; dr=0 for 4 cycles, then dr=1.
  - Response: dq=8'hEF, dv=1 held stable the whole stall; then 8'hBE; busy=1 until done.
- Simultaneous ai+go with MSB_FIRST=1:
  - Stimulus: aq preloaded 16'h1111; then ai=1, go=1, a=16'hA55A in the same cycle.
  - Response: bytes 8'hA5 then 8'h5A; aq=16'hA55A.
- Ignored inputs while busy:
  - Stimulus: ai=1, a=16'h0000, and go=1 during SECOND.
  - Response: aq unchanged; no second emission starts.
  - Then go in the done cycle → new emission starts on the next cycle.
- Aborts:
  - clr=1 with dv=1, dr=1 in FIRST → next cycle dv=0, busy=0, no done.
  - rst=0 asserted mid-SECOND → dv=0 immediately, without waiting for a clock edge, and aq=16'h0000.

Source files
------------

// File: rtl/addr_byte_serializer.sv
// Holds a 16-bit address and emits it as two bytes over a valid/ready handshake.
// Byte order is selectable; all outputs come straight from registers.
module addr_byte_serializer #(
    parameter int          MSB_FIRST   = 0,
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        ai,
    input  logic        go,
    input  logic        clr,
    input  logic        dr,
    output logic [7:0]  dq,
    output logic        dv,
    output logic [15:0] aq,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] aq_q;
    logic [7:0]  dq_q;
    logic        dv_q;
    logic        done_q;

    logic [15:0] src_d;
    logic [7:0]  first_d;
    logic [7:0]  second_d;
    logic        xfer_d;

    // A same-cycle load feeds the first byte directly (load-through).
    always_comb begin
        src_d    = ai ? a : aq_q;
        first_d  = (MSB_FIRST != 0) ? src_d[15:8] : src_d[7:0];
        second_d = (MSB_FIRST != 0) ? aq_q[7:0] : aq_q[15:8];
        xfer_d   = dv_q & dr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            aq_q    <= RESET_VALUE;
            dq_q    <= 8'h00;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr) begin
                state_q <= ST_IDLE;
                dv_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (ai) begin
                            aq_q <= a;
                        end
                        if (go) begin
                            state_q <= ST_FIRST;
                            dq_q    <= first_d;
                            dv_q    <= 1'b1;
                        end
                    end
                    ST_FIRST: begin
                        if (xfer_d) begin
                            state_q <= ST_SECOND;
                            dq_q    <= second_d;
                        end
                    end
                    ST_SECOND: begin
                        if (xfer_d) begin
                            state_q <= ST_IDLE;
                            dv_q    <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        dv_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dq   = dq_q;
    assign dv   = dv_q;
    assign aq   = aq_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_addr_byte_serializer.sv
// Directed bench for addr_byte_serializer; two instances share stimulus,
// one per byte order.
module tb_addr_byte_serializer;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic        ai;
    logic        go;
    logic        clr;
    logic        dr;

    logic [7:0]  dq0, dq1;
    logic        dv0, dv1;
    logic [15:0] aq0, aq1;
    logic        busy0, busy1;
    logic        done0, done1;

    int checks;
    int passed;

    addr_byte_serializer #(.MSB_FIRST(0), .RESET_VALUE(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .a(a), .ai(ai), .go(go), .clr(clr), .dr(dr),
        .dq(dq0), .dv(dv0), .aq(aq0), .busy(busy0), .done(done0)
    );

    addr_byte_serializer #(.MSB_FIRST(1), .RESET_VALUE(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .a(a), .ai(ai), .go(go), .clr(clr), .dr(dr),
        .dq(dq1), .dv(dv1), .aq(aq1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; dr = 1'b1; a = 16'h0; ai = 1'b0; go = 1'b0; clr = 1'b0;
        #1;
        checks++;
        if ({dq0, dv0, busy0, done0, aq0} !== {8'h00, 1'b0, 1'b0, 1'b0, 16'h0000})
            $display("FAIL reset0 got dq=%h dv=%b busy=%b done=%b aq=%h", dq0, dv0, busy0, done0, aq0);
        else passed++;
        checks++;
        if ({dq1, dv1, busy1, done1, aq1} !== {8'h00, 1'b0, 1'b0, 1'b0, 16'h0000})
            $display("FAIL reset1 got dq=%h dv=%b busy=%b done=%b aq=%h", dq1, dv1, busy1, done1, aq1);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dv0 !== 1'b0 || dv1 !== 1'b0)
                $display("FAIL idle_dv cycle %0d got dv0=%b dv1=%b want 0", i, dv0, dv1);
            else passed++;
        end
    endtask

    task automatic test_basic();
        a = 16'h14F1; ai = 1'b1; dr = 1'b1;
        @(negedge clk);
        ai = 1'b0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (dq0 !== 8'hF1 || dv0 !== 1'b1 || busy0 !== 1'b1)
            $display("FAIL basic_b0 got dq=%h dv=%b busy=%b want f1 1 1", dq0, dv0, busy0);
        else passed++;
        checks++;
        if (dq1 !== 8'h14 || dv1 !== 1'b1)
            $display("FAIL basic_msb_b0 got dq=%h dv=%b want 14 1", dq1, dv1);
        else passed++;
        @(negedge clk);
        checks++;
        if (dq0 !== 8'h14 || dv0 !== 1'b1 || done0 !== 1'b0)
            $display("FAIL basic_b1 got dq=%h dv=%b done=%b want 14 1 0", dq0, dv0, done0);
        else passed++;
        checks++;
        if (dq1 !== 8'hF1 || dv1 !== 1'b1)
            $display("FAIL basic_msb_b1 got dq=%h dv=%b want f1 1", dq1, dv1);
        else passed++;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || dv0 !== 1'b0 || busy0 !== 1'b0 || done1 !== 1'b1)
            $display("FAIL basic_done got done=%b dv=%b busy=%b done1=%b want 1 0 0 1", done0, dv0, busy0, done1);
        else passed++;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || dv0 !== 1'b0)
            $display("FAIL basic_done_pulse got done=%b dv=%b want 0 0", done0, dv0);
        else passed++;
    endtask

    task automatic test_backpressure();
        a = 16'hBEEF; ai = 1'b1; dr = 1'b0;
        @(negedge clk);
        ai = 1'b0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dq0 !== 8'hEF || dv0 !== 1'b1 || busy0 !== 1'b1 || dq1 !== 8'hBE)
                $display("FAIL stall %0d got dq=%h dv=%b busy=%b dq1=%h want ef 1 1 be", i, dq0, dv0, busy0, dq1);
            else passed++;
            if (i == 3) dr = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (dq0 !== 8'hBE || dv0 !== 1'b1 || busy0 !== 1'b1 || dq1 !== 8'hEF)
            $display("FAIL bp_b1 got dq=%h dv=%b busy=%b dq1=%h want be 1 1 ef", dq0, dv0, busy0, dq1);
        else passed++;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || dv0 !== 1'b0)
            $display("FAIL bp_done got done=%b busy=%b dv=%b want 1 0 0", done0, busy0, dv0);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_load_through();
        a = 16'h1111; ai = 1'b1; dr = 1'b1;
        @(negedge clk);
        checks++;
        if (aq1 !== 16'h1111)
            $display("FAIL lt_preload got aq=%h want 1111", aq1);
        else passed++;
        a = 16'hA55A; ai = 1'b1; go = 1'b1;
        @(negedge clk);
        ai = 1'b0; go = 1'b0;
        checks++;
        if (aq1 !== 16'hA55A || dq1 !== 8'hA5 || dv1 !== 1'b1)
            $display("FAIL lt_b0 got aq=%h dq=%h dv=%b want a55a a5 1", aq1, dq1, dv1);
        else passed++;
        checks++;
        if (dq0 !== 8'h5A)
            $display("FAIL lt_lsb_b0 got dq=%h want 5a", dq0);
        else passed++;
        @(negedge clk);
        checks++;
        if (dq1 !== 8'h5A || dv1 !== 1'b1)
            $display("FAIL lt_b1 got dq=%h dv=%b want 5a 1", dq1, dv1);
        else passed++;
        @(negedge clk);
        checks++;
        if (done1 !== 1'b1)
            $display("FAIL lt_done got done=%b want 1", done1);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_ignored();
        a = 16'h1234; ai = 1'b1; dr = 1'b1;
        @(negedge clk);
        ai = 1'b0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        dr = 1'b0; ai = 1'b1; a = 16'h0000; go = 1'b1;
        @(negedge clk);
        checks++;
        if (aq0 !== 16'h1234 || dq0 !== 8'h12 || dv0 !== 1'b1 || busy0 !== 1'b1)
            $display("FAIL ign_busy got aq=%h dq=%h dv=%b busy=%b want 1234 12 1 1", aq0, dq0, dv0, busy0);
        else passed++;
        dr = 1'b1; ai = 1'b0; go = 1'b0;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || aq0 !== 16'h1234 || busy0 !== 1'b0)
            $display("FAIL ign_done got done=%b aq=%h busy=%b want 1 1234 0", done0, aq0, busy0);
        else passed++;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (dv0 !== 1'b1 || dq0 !== 8'h34 || busy0 !== 1'b1 || done0 !== 1'b0)
            $display("FAIL b2b_b0 got dv=%b dq=%h busy=%b done=%b want 1 34 1 0", dv0, dq0, busy0, done0);
        else passed++;
        @(negedge clk);
        checks++;
        if (dq0 !== 8'h12 || dv0 !== 1'b1)
            $display("FAIL b2b_b1 got dq=%h dv=%b want 12 1", dq0, dv0);
        else passed++;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1)
            $display("FAIL b2b_done got done=%b want 1", done0);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_clr();
        a = 16'hCAFE; ai = 1'b1; dr = 1'b1;
        @(negedge clk);
        ai = 1'b0; go = 1'b1;
        @(negedge clk);
        go = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (dv0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || aq0 !== 16'hCAFE)
            $display("FAIL clr got dv=%b busy=%b done=%b aq=%h want 0 0 0 cafe", dv0, busy0, done0, aq0);
        else passed++;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || dv0 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL clr_nodone got done=%b dv=%b done1=%b want 0 0 0", done0, dv0, done1);
        else passed++;
    endtask

    task automatic test_reset_mid();
        a = 16'h5678; ai = 1'b1; dr = 1'b1;
        @(negedge clk);
        ai = 1'b0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        checks++;
        if (dq0 !== 8'h56 || dv0 !== 1'b1)
            $display("FAIL rm_second got dq=%h dv=%b want 56 1", dq0, dv0);
        else passed++;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (dv0 !== 1'b0 || aq0 !== 16'h0000 || busy0 !== 1'b0 || dq0 !== 8'h00)
            $display("FAIL rm_async got dv=%b aq=%h busy=%b dq=%h want 0 0000 0 00", dv0, aq0, busy0, dq0);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || dv0 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL rm_nodone got done=%b dv=%b done1=%b want 0 0 0", done0, dv0, done1);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_load_through();
        test_ignored();
        test_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
